// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent pushbutton debouncers with a two-flop synchroniser,
// edge pulses and a long-press (held) detector per channel.
module debounce_bank #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int STABLE_CYC = 16,
  parameter int HOLD_CYC   = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] clean,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] held,
  output logic [N_CH-1:0] held_pulse,
  output logic            any_event
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

  logic [N_CH-1:0]  s1;
  logic [N_CH-1:0]  s2;
  logic [CNT_W-1:0] stab_cnt [N_CH];
  logic [CNT_W-1:0] hold_cnt [N_CH];
  logic [N_CH-1:0]  toggle;
  logic [N_CH-1:0]  hold_hit;
  logic [N_CH-1:0]  falling;

  // A fall due on the same edge as a long-press completion wins, so held never sets as clean drops.
  always_comb begin
    toggle   = '0;
    hold_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      toggle[i]   = (s2[i] != clean[i]) && (stab_cnt[i] == STABLE_LAST);
      hold_hit[i] = clean[i] && !held[i] && !toggle[i] && (hold_cnt[i] == HOLD_LAST);
    end
  end

  assign falling = toggle & clean;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      clean      <= '0;
      rise       <= '0;
      fall       <= '0;
      held       <= '0;
      held_pulse <= '0;
      for (int i = 0; i < N_CH; i++) begin
        stab_cnt[i] <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      s1         <= button;
      s2         <= s1;
      clean      <= clean ^ toggle;
      rise       <= toggle & ~clean;
      fall       <= falling;
      held       <= (held | hold_hit) & ~falling;
      held_pulse <= hold_hit;
      for (int i = 0; i < N_CH; i++) begin
        if ((s2[i] == clean[i]) || toggle[i]) begin
          stab_cnt[i] <= '0;
        end else begin
          stab_cnt[i] <= stab_cnt[i] + 1'b1;
        end
        // Hold counter saturates at its terminal value so it can never wrap.
        if (!clean[i]) begin
          hold_cnt[i] <= '0;
        end else if (!held[i] && (hold_cnt[i] != HOLD_LAST)) begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign any_event = |{rise, fall, held_pulse};

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed scenarios plus randomized presses, checked each cycle against
// a history-based reference model through an expected-value queue.
module tb_debounce_bank;

  localparam int N_CH       = 4;
  localparam int CNT_W      = 16;
  localparam int STABLE_CYC = 4;
  localparam int HOLD_CYC   = 8;
  localparam int MAXE       = 4096;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] button;
  logic [N_CH-1:0] clean, rise, fall, held, held_pulse;
  logic            any_event;
  logic [N_CH-1:0] clean_b, rise_b, fall_b, held_b, held_pulse_b;
  logic            any_event_b;

  always #5 clk = ~clk;

  debounce_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .STABLE_CYC(STABLE_CYC), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst(rst), .button(button), .clean(clean), .rise(rise), .fall(fall),
    .held(held), .held_pulse(held_pulse), .any_event(any_event)
  );

  // Minimum-latency variant: toggles on the first disagreeing sample, holds one cycle after rise.
  debounce_bank #(.N_CH(N_CH), .CNT_W(4), .STABLE_CYC(1), .HOLD_CYC(1)) dut_min (
    .clk(clk), .rst(rst), .button(button), .clean(clean_b), .rise(rise_b), .fall(fall_b),
    .held(held_b), .held_pulse(held_pulse_b), .any_event(any_event_b)
  );

  typedef struct packed {
    logic [N_CH-1:0] clean;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] held;
    logic [N_CH-1:0] held_pulse;
    logic            any_event;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            mon;
  int              tests    = 0;
  int              failures = 0;
  logic [N_CH-1:0] smp_h   [MAXE];
  logic [N_CH-1:0] clean_h [MAXE];
  logic [N_CH-1:0] held_h  [MAXE];
  int              last_chg[N_CH];
  int              rise_t  [N_CH];
  int              t_edge = 0;
  int              rise_n, fall_n;
  logic [N_CH-1:0] lvl, noise;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, want, $time);
    end
  endtask

  // The debounce logic sees the button level captured two edges earlier (zero while in reset).
  function automatic logic sync_level(input int k, input int ch);
    return (k >= 2) ? smp_h[k-2][ch] : 1'b0;
  endfunction

  // clean flips once STABLE_CYC consecutive decisions since its last change all disagreed with it;
  // held is true once clean has been 1 for HOLD_CYC edges since its rise.
  task automatic model_step();
    exp_t            e;
    logic [N_CH-1:0] prevc, prevh, newc, newh;
    logic            tg;
    int              t = t_edge;
    prevc    = (t > 0) ? clean_h[t-1] : '0;
    prevh    = (t > 0) ? held_h[t-1] : '0;
    smp_h[t] = rst ? '0 : button;
    newc     = prevc;
    newh     = '0;
    e        = '0;
    if (rst) begin
      newc = '0;
      for (int ch = 0; ch < N_CH; ch++) last_chg[ch] = t;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        tg = (t - STABLE_CYC + 1) > last_chg[ch];
        for (int k = t - STABLE_CYC + 1; k <= t; k++) begin
          if (sync_level(k, ch) == prevc[ch]) tg = 1'b0;
        end
        if (tg) begin
          newc[ch]     = ~prevc[ch];
          last_chg[ch] = t;
          if (newc[ch]) rise_t[ch] = t;
        end
        newh[ch] = newc[ch] && ((t - rise_t[ch]) >= HOLD_CYC);
      end
      e.clean      = newc;
      e.rise       = newc & ~prevc;
      e.fall       = ~newc & prevc;
      e.held       = newh;
      e.held_pulse = newh & ~prevh;
      e.any_event  = |{e.rise, e.fall, e.held_pulse};
    end
    clean_h[t] = newc;
    held_h[t]  = newh;
    exp_q.push_back(e);
    t_edge++;
  endtask

  initial begin
    for (int ch = 0; ch < N_CH; ch++) begin
      last_chg[ch] = 0;
      rise_t[ch]   = 0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        mon = exp_q.pop_front();
        check_output("sb_clean", 32'(clean), 32'(mon.clean));
        check_output("sb_rise", 32'(rise), 32'(mon.rise));
        check_output("sb_fall", 32'(fall), 32'(mon.fall));
        check_output("sb_held", 32'(held), 32'(mon.held));
        check_output("sb_held_pulse", 32'(held_pulse), 32'(mon.held_pulse));
        check_output("sb_any_event", 32'(any_event), 32'(mon.any_event));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input logic [N_CH-1:0] b, input logic r);
    button = b;
    rst    = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus('0, 1'b0);
  endtask

  initial begin
    repeat (3) apply_stimulus('0, 1'b1);
    idle(4);

    // Clean press on channel 0, also watched on the minimum-latency instance.
    for (int e = 1; e <= 8; e++) begin
      apply_stimulus(4'b0001, 1'b0);
      check_output("press_clean", 32'(clean), 32'((e >= 6) ? 4'b0001 : 4'b0000));
      check_output("press_rise", 32'(rise), 32'((e == 6) ? 4'b0001 : 4'b0000));
      check_output("press_any", 32'(any_event), 32'(e == 6));
      check_output("min_clean", 32'(clean_b), 32'((e >= 3) ? 4'b0001 : 4'b0000));
      check_output("min_rise", 32'(rise_b), 32'((e == 3) ? 4'b0001 : 4'b0000));
      check_output("min_held", 32'(held_b), 32'((e >= 4) ? 4'b0001 : 4'b0000));
      check_output("min_held_pulse", 32'(held_pulse_b), 32'((e == 4) ? 4'b0001 : 4'b0000));
      check_output("min_fall", 32'(fall_b), 32'(4'b0000));
      check_output("min_any", 32'(any_event_b), 32'((e == 3) || (e == 4)));
    end
    idle(24);

    for (int e = 1; e <= 12; e++) begin
      apply_stimulus((e <= 3) ? 4'b0010 : 4'b0000, 1'b0);
      check_output("glitch_clean", 32'(clean), 32'(4'b0000));
      check_output("glitch_rise", 32'(rise), 32'(4'b0000));
      check_output("glitch_fall", 32'(fall), 32'(4'b0000));
    end
    idle(8);

    for (int e = 1; e <= 30; e++) begin
      apply_stimulus((e <= 20) ? 4'b0100 : 4'b0000, 1'b0);
      check_output("long_clean", 32'(clean[2]), 32'((e >= 6) && (e < 26)));
      check_output("long_rise", 32'(rise[2]), 32'(e == 6));
      check_output("long_held", 32'(held[2]), 32'((e >= 14) && (e < 26)));
      check_output("long_held_pulse", 32'(held_pulse[2]), 32'(e == 14));
      check_output("long_fall", 32'(fall[2]), 32'(e == 26));
    end
    idle(24);

    for (int e = 1; e <= 12; e++) begin
      apply_stimulus(4'b1111, 1'b0);
      check_output("simul_rise", 32'(rise), 32'((e == 6) ? 4'b1111 : 4'b0000));
      check_output("simul_any", 32'(any_event), 32'(e == 6));
    end
    idle(24);

    // Reset lands while channel 0 is two samples into its count.
    for (int e = 1; e <= 14; e++) begin
      apply_stimulus(4'b0001, e == 5);
      if (e == 5) begin
        check_output("rst_held", 32'(held), 32'(4'b0000));
        check_output("rst_any", 32'(any_event), 32'(0));
      end
      if (e >= 5) begin
        check_output("rst_clean", 32'(clean[0]), 32'(e >= 11));
        check_output("rst_rise", 32'(rise[0]), 32'(e == 11));
      end
    end
    idle(24);

    rise_n = 0;
    fall_n = 0;
    for (int e = 1; e <= 40; e++) begin
      apply_stimulus(((e > 20) || ((((e - 1) / 2) % 2) == 0)) ? 4'b1000 : 4'b0000, 1'b0);
      if (rise[3]) rise_n++;
      if (fall[3]) fall_n++;
    end
    check_output("bounce_rises", 32'(rise_n), 32'(1));
    check_output("bounce_falls", 32'(fall_n), 32'(0));
    idle(24);

    lvl = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if ($urandom_range(0, 9) == 0) lvl[ch] = ~lvl[ch];
      end
      noise = ($urandom_range(0, 19) == 0) ? N_CH'($urandom_range(0, 15)) : '0;
      apply_stimulus(lvl ^ noise, $urandom_range(0, 399) == 0);
    end
    idle(4);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
